// File: rtl/frame_tx_pkg.sv
// Shared framing constants, state encoding and byte helpers for the serial
// frame transmitter (header values are shared with the receive framer).
package frame_tx_pkg;

   localparam logic [7:0] HDR_A_DEF     = 8'hA5;
   localparam logic [7:0] HDR_B_DEF     = 8'h5A;
   localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

   localparam int         PAYLOAD_BYTES = 8;
   localparam logic [2:0] LAST_IDX      = 3'(PAYLOAD_BYTES - 1);

   localparam int FRAME_BYTES_CHK    = PAYLOAD_BYTES + 3;
   localparam int FRAME_BYTES_NOCHK  = PAYLOAD_BYTES + 2;
   localparam int FRAME_CYCLES_CHK   = 8 * FRAME_BYTES_CHK;
   localparam int FRAME_CYCLES_NOCHK = 8 * FRAME_BYTES_NOCHK;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_A,
      ST_HDR_B,
      ST_PAYLOAD,
      ST_CHK
   } tx_state_e;

   // Byte idx of a payload word, idx 0 being the most significant byte.
   function automatic logic [7:0] word_byte(input logic [63:0] w, input logic [2:0] idx);
      return w[(7 - int'(idx)) * 8 +: 8];
   endfunction

endpackage

// File: rtl/frame_tx_if.sv
// Payload handshake and serial-side outputs of the frame transmitter.
interface frame_tx_if;
   logic [63:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic        ser_out;
   logic        sof;
   logic        tx_active;

   modport master (
      output data_in, valid_in,
      input  ready_out, ser_out, sof, tx_active
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, ser_out, sof, tx_active
   );
endinterface

// File: rtl/frame_tx_piso_byte8.sv
// 8-bit parallel-load shift register, MSB first, with a free-running bit
// counter; a new byte is taken only when the counter wraps 7->0.
module frame_tx_piso_byte8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] load_byte,
   output logic       ser_out,
   output logic [2:0] bit_cnt,
   output logic       byte_end
);

   logic [7:0] sr_q;

   assign byte_end = (bit_cnt == 3'd7);
   assign ser_out  = sr_q[7];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q    <= '0;
         bit_cnt <= '0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         sr_q    <= byte_end ? load_byte : {sr_q[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: one-word holding register, framing FSM and XOR
// checksum in front of a byte-aligned PISO.
module frame_tx
   import frame_tx_pkg::*;
#(
   parameter logic [7:0] HDR_A     = HDR_A_DEF,
   parameter logic [7:0] HDR_B     = HDR_B_DEF,
   parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
   parameter bit         CHK_EN    = 1'b1
) (
   input logic       ser_clk,
   input logic       reset_n,
   frame_tx_if.slave tx
);

   tx_state_e   state_q, state_d;
   logic [2:0]  byte_idx_q, byte_idx_d, idx_inc;
   logic [7:0]  chk_q, chk_d;
   logic [63:0] hold_q, payload_q;
   logic        hold_vld_q, hold_vld_d;
   logic        ready_q;
   logic        accept, move, frame_end;
   logic [7:0]  load_byte;
   logic [2:0]  bit_cnt;
   logic        byte_end;
   logic        ser_bit;

   frame_tx_piso_byte8 u_piso (
      .clk       (ser_clk),
      .rst_n     (reset_n),
      .load_byte (load_byte),
      .ser_out   (ser_bit),
      .bit_cnt   (bit_cnt),
      .byte_end  (byte_end)
   );

   // ready is a flop, so valid_in never reaches ready_out combinationally.
   assign accept = tx.valid_in && ready_q;

   // state_q names the byte currently on the line; it only changes at byte_end.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      chk_d      = chk_q;
      load_byte  = IDLE_BYTE;
      move       = 1'b0;
      frame_end  = 1'b0;
      idx_inc    = byte_idx_q + 3'd1;
      if (byte_end) begin
         case (state_q)
            ST_IDLE: move = hold_vld_q;
            ST_HDR_A: begin
               state_d   = ST_HDR_B;
               load_byte = HDR_B;
            end
            ST_HDR_B: begin
               state_d    = ST_PAYLOAD;
               byte_idx_d = '0;
               load_byte  = word_byte(payload_q, 3'd0);
               chk_d      = chk_q ^ load_byte;
            end
            ST_PAYLOAD: begin
               if (byte_idx_q != LAST_IDX) begin
                  byte_idx_d = idx_inc;
                  load_byte  = word_byte(payload_q, idx_inc);
                  chk_d      = chk_q ^ load_byte;
               end else if (CHK_EN) begin
                  state_d   = ST_CHK;
                  load_byte = chk_q;
               end else begin
                  frame_end = 1'b1;
               end
            end
            ST_CHK:  frame_end = 1'b1;
            default: state_d = ST_IDLE;
         endcase
         if (frame_end) begin
            move    = hold_vld_q;
            state_d = ST_IDLE;
         end
         // A pending word starts its header with no idle gap.
         if (move) begin
            state_d   = ST_HDR_A;
            load_byte = HDR_A;
            chk_d     = '0;
         end
      end
      hold_vld_d = move ? 1'b0 : (accept ? 1'b1 : hold_vld_q);
   end

   always_ff @(posedge ser_clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= '0;
         chk_q      <= '0;
         hold_vld_q <= 1'b0;
         ready_q    <= 1'b0;
         hold_q     <= '0;
         payload_q  <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         chk_q      <= chk_d;
         hold_vld_q <= hold_vld_d;
         ready_q    <= !hold_vld_d;
         if (accept) hold_q    <= tx.data_in;
         if (move)   payload_q <= hold_q;
      end
   end

   assign tx.ready_out = ready_q;
   assign tx.ser_out   = ser_bit;
   assign tx.sof       = (state_q == ST_HDR_A) && (bit_cnt == 3'd0);
   assign tx.tx_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: one instance with checksum, one without,
// checked against a byte-level frame model and a free-running slot counter.
module tb_frame_tx;

   logic clk = 1'b0;
   logic reset_n;
   int   nvec = 0;
   int   nerr = 0;
   int   slot = 0;

   always #5 clk = ~clk;

   // Slot counter: its value mod 8 is the bit position within the current byte.
   always @(posedge clk) begin
      if (!reset_n) slot <= 0;
      else          slot <= slot + 1;
   end

   frame_tx_if if1 ();
   frame_tx_if if0 ();

   frame_tx #(.CHK_EN(1'b1)) dut1 (.ser_clk(clk), .reset_n(reset_n), .tx(if1));
   frame_tx #(.CHK_EN(1'b0)) dut0 (.ser_clk(clk), .reset_n(reset_n), .tx(if0));

   logic cs [0:255];
   logic ca [0:255];
   logic cf [0:255];
   logic cr [0:255];

   function automatic logic o_ser(input bit d); return d ? if1.ser_out   : if0.ser_out;   endfunction
   function automatic logic o_act(input bit d); return d ? if1.tx_active : if0.tx_active; endfunction
   function automatic logic o_sof(input bit d); return d ? if1.sof       : if0.sof;       endfunction
   function automatic logic o_rdy(input bit d); return d ? if1.ready_out : if0.ready_out; endfunction

   task automatic set_valid(input bit d, input logic v);
      if (d) if1.valid_in = v;
      else   if0.valid_in = v;
   endtask

   task automatic set_data(input logic [63:0] w);
      if1.data_in = w;
      if0.data_in = w;
   endtask

   // Expected k-th byte on the wire for a frame carrying w.
   function automatic logic [7:0] exp_byte(input logic [63:0] w, input int k);
      logic [7:0] x;
      x = 8'h00;
      if (k == 0) return 8'hA5;
      if (k == 1) return 8'h5A;
      if (k < 10) return w[8 * (9 - k) +: 8];
      for (int j = 0; j < 8; j++) x = x ^ w[8 * j +: 8];
      return x;
   endfunction

   function automatic logic [7:0] cap_byte(input int k);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], cs[8 * k + i]};
      return b;
   endfunction

   task automatic capture(input bit d, input int n, input int drop_at);
      for (int i = 0; i < n; i++) begin
         cs[i] = o_ser(d);
         ca[i] = o_act(d);
         cf[i] = o_sof(d);
         cr[i] = o_rdy(d);
         if (i == drop_at) set_valid(d, 1'b0);
         @(negedge clk);
      end
   endtask

   task automatic wait_sof(input bit d, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (o_sof(d)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_valid(1'b1, 1'b0);
      set_valid(1'b0, 1'b0);
      set_data('0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nvec++;
         if (if1.ser_out !== 1'b0 || if1.ready_out !== 1'b0 || if0.ready_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_hold cyc %0d: ser=%b rdy1=%b rdy0=%b, required 0/0/0",
                     i, if1.ser_out, if1.ready_out, if0.ready_out);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      nvec++;
      if (if1.ready_out !== 1'b1 || if0.ready_out !== 1'b1) begin
         nerr++;
         $display("FAIL reset_release_ready: rdy1=%b rdy0=%b, required 1", if1.ready_out, if0.ready_out);
      end
      for (int i = 0; i < 32; i++) begin
         nvec++;
         if (if1.ser_out !== 1'b0 || if1.tx_active !== 1'b0 || if1.sof !== 1'b0 ||
             if0.ser_out !== 1'b0 || if0.tx_active !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle cyc %0d: ser=%b act=%b sof=%b, required 0", i,
                     if1.ser_out, if1.tx_active, if1.sof);
         end
         @(negedge clk);
      end
   endtask

   // One complete frame through instance d (1: checksum on, 0: off).
   task automatic test_frame(input bit d, input logic [63:0] w);
      bit ok;
      int s1, exp_slot, nb, nact, nsof, nbad;
      logic [7:0] got, want;
      nb = d ? 11 : 10;
      set_data(w);
      set_valid(d, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (o_rdy(d)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL frame_accept_timeout chk=%0d: ready never 1, required 1", d);
         set_valid(d, 1'b0);
         return;
      end
      s1 = slot + 1;
      @(negedge clk);
      set_valid(d, 1'b0);
      nvec++;
      if (o_rdy(d) !== 1'b0) begin
         nerr++;
         $display("FAIL frame_ready_drop chk=%0d: ready=%b, required 0", d, o_rdy(d));
      end
      // Header starts at the first byte boundary the held word can meet.
      exp_slot = (s1 / 8 + 1) * 8;
      wait_sof(d, 16, ok);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL frame_sof_timeout chk=%0d: no sof, required sof at slot %0d", d, exp_slot);
         return;
      end
      nvec++;
      if (slot !== exp_slot) begin
         nerr++;
         $display("FAIL frame_sof_slot chk=%0d: sof at slot %0d, required %0d", d, slot, exp_slot);
      end
      capture(d, nb * 8 + 16, -1);
      for (int k = 0; k < nb; k++) begin
         got  = cap_byte(k);
         want = exp_byte(w, k);
         nvec++;
         if (got !== want) begin
            nerr++;
            $display("FAIL frame_byte chk=%0d word=%h byte %0d: got %h, required %h", d, w, k, got, want);
         end
      end
      nact = 0; nsof = 0; nbad = 0;
      for (int i = 0; i < nb * 8 + 16; i++) begin
         if (i < nb * 8 && ca[i] === 1'b1) nact++;
         if (cf[i] === 1'b1) nsof++;
         if (i >= nb * 8 && (ca[i] !== 1'b0 || cs[i] !== 1'b0)) nbad++;
      end
      nvec++;
      if (nact !== nb * 8) begin
         nerr++;
         $display("FAIL frame_active_len chk=%0d: %0d active cycles, required %0d", d, nact, nb * 8);
      end
      nvec++;
      if (nsof !== 1 || cf[0] !== 1'b1) begin
         nerr++;
         $display("FAIL frame_sof_count chk=%0d: %0d sof pulses, required 1", d, nsof);
      end
      nvec++;
      if (nbad !== 0) begin
         nerr++;
         $display("FAIL frame_idle_tail chk=%0d: %0d non-idle cycles, required 0", d, nbad);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] w1, w2;
      logic [7:0]  got, want;
      bit ok;
      int nact, nbad, nrdy;
      w1 = 64'h1111111111111111;
      w2 = 64'h2222222222222222;
      set_data(w1);
      if1.valid_in = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (if1.ready_out) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL b2b_accept_timeout: ready never 1, required 1");
         if1.valid_in = 1'b0;
         return;
      end
      @(negedge clk);
      set_data(w2);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (if1.sof) begin
            ok = 1'b1;
            break;
         end
         nvec++;
         if (if1.ready_out !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_ready_held: ready=%b before first sof, required 0", if1.ready_out);
         end
         @(negedge clk);
      end
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL b2b_sof_timeout: no first sof, required one");
         if1.valid_in = 1'b0;
         return;
      end
      capture(1'b1, 192, 1);
      for (int k = 0; k < 22; k++) begin
         got  = cap_byte(k);
         want = (k < 11) ? exp_byte(w1, k) : exp_byte(w2, k - 11);
         nvec++;
         if (got !== want) begin
            nerr++;
            $display("FAIL b2b_byte %0d: got %h, required %h", k, got, want);
         end
      end
      nvec++;
      if (cr[0] !== 1'b1 || cr[88] !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_ready_moves: ready at frame starts %b/%b, required 1/1", cr[0], cr[88]);
      end
      nrdy = 0; nact = 0; nbad = 0;
      for (int i = 1; i < 88; i++) if (cr[i] !== 1'b0) nrdy++;
      for (int i = 0; i < 192; i++) begin
         if (i < 176 && ca[i] === 1'b1) nact++;
         if (cf[i] !== ((i == 0 || i == 88) ? 1'b1 : 1'b0)) nbad++;
         if (i >= 176 && (ca[i] !== 1'b0 || cs[i] !== 1'b0)) nbad++;
      end
      nvec++;
      if (nrdy !== 0) begin
         nerr++;
         $display("FAIL b2b_ready_low: ready high in %0d cycles while W2 held, required 0", nrdy);
      end
      nvec++;
      if (nact !== 176) begin
         nerr++;
         $display("FAIL b2b_active_len: %0d active cycles, required 176", nact);
      end
      nvec++;
      if (nbad !== 0) begin
         nerr++;
         $display("FAIL b2b_sof_idle: %0d bad sof/idle cycles, required 0", nbad);
      end
   endtask

   task automatic test_alignment();
      for (int i = 0; i < 16; i++) begin
         if (slot % 8 == 3) break;
         @(negedge clk);
      end
      set_data({$urandom, $urandom});
      if1.valid_in = 1'b1;
      nvec++;
      if (if1.ready_out !== 1'b1 || slot % 8 != 3) begin
         nerr++;
         $display("FAIL align_start: ready=%b slot=%0d, required ready 1 at slot 3", if1.ready_out, slot % 8);
      end
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) if1.valid_in = 1'b0;
         nvec++;
         if (if1.sof !== ((i == 5) ? 1'b1 : 1'b0)) begin
            nerr++;
            $display("FAIL align_sof cycle +%0d: sof=%b, required %b", i, if1.sof, (i == 5));
         end
      end
   endtask

   // Runs straight on from test_alignment, which leaves us in the sof cycle.
   task automatic test_reset_mid_frame();
      int nbad;
      set_data({$urandom, $urandom});
      if1.valid_in = 1'b1;
      nvec++;
      if (if1.ready_out !== 1'b1) begin
         nerr++;
         $display("FAIL midrst_ready_pre: ready=%b, required 1", if1.ready_out);
      end
      @(negedge clk);
      if1.valid_in = 1'b0;
      nvec++;
      if (if1.ready_out !== 1'b0) begin
         nerr++;
         $display("FAIL midrst_held: ready=%b, required 0", if1.ready_out);
      end
      repeat (50) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      nvec++;
      if (if1.ser_out !== 1'b0 || if1.tx_active !== 1'b0 || if1.ready_out !== 1'b0) begin
         nerr++;
         $display("FAIL midrst_abort: ser=%b act=%b rdy=%b, required 0/0/0",
                  if1.ser_out, if1.tx_active, if1.ready_out);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      nvec++;
      if (if1.ready_out !== 1'b1) begin
         nerr++;
         $display("FAIL midrst_ready_post: ready=%b, required 1", if1.ready_out);
      end
      nbad = 0;
      for (int i = 0; i < 200; i++) begin
         if (if1.ser_out !== 1'b0 || if1.tx_active !== 1'b0 || if1.sof !== 1'b0) nbad++;
         @(negedge clk);
      end
      nvec++;
      if (nbad !== 0) begin
         nerr++;
         $display("FAIL midrst_discard: %0d non-idle cycles after reset, required 0", nbad);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish, required finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_frame(1'b1, 64'h0123456789ABCDEF);
      test_frame(1'b1, 64'hFF00000000000001);
      test_frame(1'b0, 64'hFF00000000000001);
      test_back_to_back();
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 11)) @(negedge clk);
         test_frame(r[0], {$urandom, $urandom});
      end
      test_alignment();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/frame_tx.md
Name: frame_tx

Overview:
- Serial frame transmitter: the transmit-side counterpart of the receive framer.
- Accepts 64-bit payload words through a valid/ready handshake and serialises each word MSB-first on ser_out at ser_clk rate.
- Each frame is wrapped in the two-byte A/B header the receive framer locks on, with an optional XOR checksum byte.
- Drives the serial link feeding the receive chain. Between frames it emits a continuous idle byte, so byte alignment is never lost.

Parameters:
- HDR_A, 8'hA5, first header byte.
- HDR_B, 8'h5A, second header byte.
- IDLE_BYTE, 8'h00, fill byte sent when no frame is pending. Must differ from HDR_A and HDR_B.
- PAYLOAD_BYTES, 8, payload bytes per frame. Fixed at 8 to match the 64-bit data_in width.
- CHK_EN, 1, 1 = append checksum byte (XOR of all payload bytes); 0 = no checksum.

Ports:
- ser_clk, in, 1, bit clock; all logic on the rising edge.
- reset_n, in, 1, synchronous, active-low reset.
- data_in, in, 64, payload word; byte 0 = data_in[63:56] is sent first.
- valid_in, in, 1, data_in valid.
- ready_out, out, 1, holding register empty. Transfer occurs on an edge where valid_in && ready_out.
- ser_out, out, 1, serial output, registered.
- sof, out, 1, high for exactly the one cycle in which ser_out carries HDR_A bit 7.
- tx_active, out, 1, high while ser_out carries any header, payload or checksum bit.

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE, bit_cnt=0, hold empty, checksum=0.
  - ser_out=0, sof=0, tx_active=0, ready_out=0.
  - ready_out rises on the first edge with reset_n high.
- Reset mid-frame aborts the frame immediately; the held word is discarded.
- Byte timing:
  - 3-bit bit_cnt increments every cycle and wraps 7->0; bit_cnt=0 is the MSB slot.
  - The shift register loads the next byte only at the wrap, so every byte, idle or frame, is 8-cycle aligned.
- Holding register:
  - One entry. ready_out = registered !hold_valid.
  - Accepting a word sets hold_valid on that edge; ready_out drops the next cycle.
  - No combinational path from valid_in to ready_out.
  - While ready_out=0, valid_in/data_in must be held by the source and are ignored by this block.
- State machine: IDLE -> HDR_A -> HDR_B -> PAYLOAD (8 bytes, byte counter 0..7) -> CHK (only if CHK_EN) -> IDLE or HDR_A.
  - IDLE: shift IDLE_BYTE.
    - At a byte boundary with hold_valid=1: load HDR_A and move the held word into the payload register.
    - Clear hold_valid in that move; ready_out=1 from the next cycle.
    - sof=1 for the first HDR_A bit.
  - HDR_A -> HDR_B -> PAYLOAD: advance at byte boundaries only.
  - PAYLOAD: shift the payload register MSB-first. Checksum XOR-accumulates each payload byte as it is loaded.
  - End of last frame byte (last payload byte, or CHK when enabled):
    - hold_valid=1: go straight to HDR_A, no idle gap (back-to-back frames).
    - hold_valid=0: go to IDLE.
  - The checksum clears when HDR_A loads.
- Latency: the first HDR_A bit appears at the first byte boundary after the accept edge, 1 to 8 cycles later.
- Frame length: 88 cycles with CHK_EN=1, 80 with CHK_EN=0.
- A word accepted during a frame is transmitted next. A third word is not accepted until the held word moves to the payload register.
- tx_active=1 for every frame bit, 0 for idle bits.

Decomposition:
- Shared include/package frame_defs:
  - HDR_A, HDR_B and IDLE_BYTE defaults.
  - state encoding localparams (IDLE, HDR_A, HDR_B, PAYLOAD, CHK).
  - frame length constants.
- The same header constants are used by the receive framer.
- One natural sub-module: piso_byte8, an 8-bit parallel-load shift register with bit counter and byte-boundary strobe.
- FSM, holding register and checksum stay in frame_tx.

Test Plan:
- Reset: hold reset_n=0 for 4 cycles.
  - -> ser_out=0, ready_out=0 throughout.
  - ready_out=1 on the first cycle after release.
  - ser_out continuous 0 (IDLE_BYTE) and tx_active=0 for 32 cycles.
- Single frame: accept 64'h0123456789ABCDEF.
  - -> sof at the next byte boundary.
  - ser_out bytes A5,5A,01,23,45,67,89,AB,CD,EF,00 (checksum 8'h00), MSB first.
  - tx_active high for 88 cycles, then idle 00 bytes.
- Checksum: accept 64'hFF00000000000001.
  - -> checksum byte 8'hFE.
  - With CHK_EN=0 the same word gives an 80-bit frame with no checksum.
- Back-to-back: offer words W1=64'h1111..., W2=64'h2222... continuously.
  - -> W2 accepted 1 cycle after W1 moves to the payload register.
  - Frames contiguous, second sof exactly 88 cycles after the first, no idle byte between.
  - ready_out low until W2 moves to the payload register.
- Alignment: assert valid_in when bit_cnt=3 during idle.
  - -> sof exactly 5 cycles later (at bit_cnt=0).
- Reset mid-frame: assert reset_n=0 during payload byte 4 with a word held.
  - -> next cycle ser_out=0, tx_active=0, ready_out=0.
  - After release, only idle bytes are sent; the held word is not transmitted.
